// File: rtl/shiftreg_frontend_pkg.sv
// Shared constants and helpers for the shift-register front end.
// Default parameter values used by the top and the input conditioner.
package shiftreg_frontend_pkg;

    localparam logic SHIFT_MSB_FIRST = 1'b0;
    localparam logic SHIFT_LSB_FIRST = 1'b1;

    localparam int DEF_WIDTH           = 8;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shiftreg_frontend_input_conditioner.sv
// Synchroniser plus debouncer for one raw board input.
// Emits the conditioned level and registered one-cycle edge pulses.
module input_conditioner
    import shiftreg_frontend_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   level_q, level_d;
    logic [DB_W-1:0]        cnt_q, cnt_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync != level_q) begin
            if (cnt_q == DB_LAST) begin
                level_d = sync;
                rise_d  = sync;
                fall_d  = ~sync;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/shiftreg_frontend.sv
// Debounced button/switch front end driving a WIDTH-bit shift register.
// Define SHIFTREG_FRONTEND_FRAME_EN to build the frame counter and frame_done.
module shiftreg_frontend
    import shiftreg_frontend_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             button0,
    input  logic             switch0,
    input  logic             switch1,
    input  logic             lsb_first,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] parallel_out,
    output logic             serial_out,
    output logic             frame_done
);

    logic btn_level, btn_rise, btn_fall;
    logic sw0_level, sw0_rise, sw0_fall;
    logic sw1_level, sw1_rise, sw1_fall;
    logic load, shift;
    logic unused_sig;

    input_conditioner #(
        .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn0 (
        .clk(clk), .rst_n(rst_n), .raw_i(button0),
        .level_o(btn_level), .rise_o(btn_rise), .fall_o(btn_fall)
    );

    input_conditioner #(
        .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw0 (
        .clk(clk), .rst_n(rst_n), .raw_i(switch0),
        .level_o(sw0_level), .rise_o(sw0_rise), .fall_o(sw0_fall)
    );

    input_conditioner #(
        .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw1 (
        .clk(clk), .rst_n(rst_n), .raw_i(switch1),
        .level_o(sw1_level), .rise_o(sw1_rise), .fall_o(sw1_fall)
    );

    assign unused_sig = &{1'b0, btn_level, btn_rise, sw0_rise,
                          sw0_fall, sw1_level, sw1_fall};

    // Load has priority: a coincident shift is dropped entirely.
    assign load  = btn_fall;
    assign shift = sw1_rise & ~btn_fall;

    logic [WIDTH-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        unique case (1'b1)
            load:                                  sr_d = parallel_in;
            shift && (lsb_first == SHIFT_LSB_FIRST): sr_d = {sw0_level, sr_q[WIDTH-1:1]};
            shift && (lsb_first == SHIFT_MSB_FIRST): sr_d = {sr_q[WIDTH-2:0], sw0_level};
            default:                               sr_d = sr_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign parallel_out = sr_q;
    assign serial_out   = (lsb_first == SHIFT_LSB_FIRST) ? sr_q[0] : sr_q[WIDTH-1];

`ifdef SHIFTREG_FRONTEND_FRAME_EN
    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frame_q, frame_d;

    always_comb begin
        cnt_d   = cnt_q;
        frame_d = 1'b0;
        if (load) begin
            cnt_d = '0;
        end else if (shift) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                frame_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
        end
    end

    assign frame_done = frame_q;
`else
    assign frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_shiftreg_frontend.sv
// Directed scoreboard bench for shiftreg_frontend (WIDTH=8, SYNC=2, DEBOUNCE=4).
// Frame expectations follow SHIFTREG_FRONTEND_FRAME_EN.
module tb_shiftreg_frontend;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       button0, switch0, switch1, lsb_first;
    logic [7:0] parallel_in;
    logic [7:0] parallel_out;
    logic       serial_out;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

`ifdef SHIFTREG_FRONTEND_FRAME_EN
    localparam bit FRAME_EN = 1'b1;
`else
    localparam bit FRAME_EN = 1'b0;
`endif

    logic [8:0] sb_q[$];
    logic [7:0] exp_reg;
    int         exp_cnt;

    shiftreg_frontend #(
        .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .button0(button0), .switch0(switch0), .switch1(switch1),
        .lsb_first(lsb_first), .parallel_in(parallel_in),
        .parallel_out(parallel_out), .serial_out(serial_out),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    // Expected outputs for one accepted shift, pushed when the shift is driven.
    task automatic model_shift(input logic s0);
        logic frame;
        if (lsb_first) exp_reg = {s0, exp_reg[7:1]};
        else           exp_reg = {exp_reg[6:0], s0};
        frame = 1'b0;
        if (exp_cnt == 7) begin
            exp_cnt = 0;
            frame   = FRAME_EN;
        end else begin
            exp_cnt++;
        end
        sb_q.push_back({frame, exp_reg});
    endtask

    task automatic check_out(input string tag);
        logic [8:0] e;
        logic       ser;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty scoreboard expected=entry", tag);
        end else begin
            e   = sb_q.pop_front();
            ser = lsb_first ? e[0] : e[7];
            chk(tag, parallel_out, e[7:0]);
            chk({tag, "_ser"}, {7'b0, serial_out}, {7'b0, ser});
            chk({tag, "_frm"}, {7'b0, frame_done}, {7'b0, e[8]});
        end
    endtask

    task automatic do_shift(input string tag);
        logic [7:0] prev;
        prev    = exp_reg;
        switch1 = 1'b1;
        model_shift(switch0);
        step(6);
        chk({tag, "_pre"}, parallel_out, prev);
        step(1);
        check_out(tag);
        step(1);
        chk({tag, "_frm_end"}, {7'b0, frame_done}, 8'h00);
        switch1 = 1'b0;
        step(7);
    endtask

    task automatic do_load(input logic [7:0] v, input string tag);
        button0 = 1'b1;
        step(7);
        parallel_in = v;
        button0     = 1'b0;
        exp_reg     = v;
        exp_cnt     = 0;
        sb_q.push_back({1'b0, v});
        step(7);
        check_out(tag);
    endtask

    task automatic set_s0(input logic v);
        switch0 = v;
        step(7);
    endtask

    initial begin
        rst_n       = 1'b0;
        button0     = 1'b0;
        switch0     = 1'b0;
        switch1     = 1'b0;
        lsb_first   = 1'b0;
        parallel_in = 8'h00;
        exp_reg     = 8'h00;
        exp_cnt     = 0;
        #1;
        chk("rst_po", parallel_out, 8'h00);
        chk("rst_ser", {7'b0, serial_out}, 8'h00);
        chk("rst_frm", {7'b0, frame_done}, 8'h00);
        step(2);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("idle_po", parallel_out, 8'h00);
            chk("idle_ser", {7'b0, serial_out}, 8'h00);
            chk("idle_frm", {7'b0, frame_done}, 8'h00);
        end

        set_s0(1'b1);
        switch1 = 1'b1;
        step(3);
        switch1 = 1'b0;
        step(10);
        chk("glitch", parallel_out, 8'h00);

        switch1 = 1'b1;
        model_shift(1'b1);
        step(6);
        chk("held_pre", parallel_out, 8'h00);
        step(1);
        check_out("held");
        step(3);
        switch1 = 1'b0;
        step(7);
        chk("held_once", parallel_out, 8'h01);

        do_load(8'hA5, "ld_a5");
        for (int i = 0; i < 8; i++) do_shift("a5_shift");
        chk("a5_final", parallel_out, 8'hFF);

        lsb_first = 1'b1;
        do_load(8'h81, "ld_81");
        set_s0(1'b0);
        do_shift("lsb_shift");
        chk("lsb_val", parallel_out, 8'h40);
        chk("lsb_ser", {7'b0, serial_out}, 8'h00);

        lsb_first = 1'b0;
        set_s0(1'b1);
        button0 = 1'b1;
        step(7);
        parallel_in = 8'h3C;
        button0     = 1'b0;
        switch1     = 1'b1;
        exp_reg     = 8'h3C;
        exp_cnt     = 0;
        sb_q.push_back({1'b0, 8'h3C});
        step(7);
        check_out("ld_and_shift");
        switch1 = 1'b0;
        step(7);
        for (int i = 0; i < 7; i++) do_shift("post_ld_shift");
        do_shift("post_ld_8th");

        do_load(8'h5A, "ld_5a");
        for (int i = 0; i < 5; i++) do_shift("pre_rst_shift");
        switch1 = 1'b1;
        step(3);
        rst_n = 1'b0;
        #1;
        chk("arst_po", parallel_out, 8'h00);
        chk("arst_ser", {7'b0, serial_out}, 8'h00);
        chk("arst_frm", {7'b0, frame_done}, 8'h00);
        step(2);
        rst_n   = 1'b1;
        exp_reg = 8'h00;
        exp_cnt = 0;
        model_shift(1'b1);
        step(6);
        chk("rel_pre", parallel_out, 8'h00);
        step(1);
        check_out("rel_shift");
        switch1 = 1'b0;
        step(7);
        for (int i = 0; i < 7; i++) do_shift("rel_more");

        chk("sb_drained", 8'(sb_q.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shiftreg_frontend.md
# shiftreg_frontend

Parametrised successor to the fixed 8-bit board-level shift-register front end: three debounced, synchronised user inputs drive a WIDTH-bit shift register. The block adds configurable conditioning depth, selectable shift direction, a serial output, and an optional frame counter that flags when WIDTH bits have been shifted. It sits between board pins (button, switches) and the SPI datapath, for bring-up and manual serial exercise.

## Interface
- WIDTH, 8, shift register width; must be ≥ 2.
- SYNC_STAGES, 2, synchroniser flops per input; must be ≥ 2.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a conditioned output changes; must be ≥ 1.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- button0  in  1  raw load button; its conditioned falling edge loads parallel_in.
- switch0  in  1  raw serial data; the conditioned level is the shift-in bit.
- switch1  in  1  raw manual shift clock; its conditioned rising edge triggers one shift.
- lsb_first  in  1  direction select: 0 = shift toward MSB, 1 = shift toward LSB. Quasi-static; sampled on each shift cycle, not conditioned.
- parallel_in  in  WIDTH  load data.
- parallel_out  out  WIDTH  shift register contents.
- serial_out  out  1  outgoing bit: parallel_out[WIDTH-1] when lsb_first=0, otherwise parallel_out[0]; combinational from register and lsb_first.
- frame_done  out  1  one-cycle pulse when WIDTH shifts have completed since the last load or reset.

## Operation
- Reset (rst_n low, any time): synchroniser flops, conditioned levels, debounce counters, edge pulses, shift register, bit counter and frame_done all go to 0.
- Each input has its own conditioner instance:
  - SYNC_STAGES-flop synchroniser.
  - Debounce counter: increments each cycle the synchronised value differs from the conditioned level, and clears each cycle they match.
  - When the counter is at DEBOUNCE_CYCLES-1 and the values still differ, on the next edge the conditioned level takes the synchronised value, the counter clears, and a registered one-cycle posedge or negedge pulse fires in the same cycle.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the conditioned level.
- Load (button0 negedge pulse): register <= parallel_in; bit counter <= 0.
- Shift (switch1 posedge pulse, no load in the same cycle):
  - lsb_first=0: register <= {register[WIDTH-2:0], s0}.
  - lsb_first=1: register <= {s0, register[WIDTH-1:1]}.
  - s0 is the conditioned switch0 level before that edge.
- Load and shift in the same cycle: the load wins; the shift is dropped and the counter does not advance.
- Frame counter, $clog2(WIDTH+1) bits, increments on each accepted shift. On the shift that makes the count WIDTH, frame_done pulses in the following cycle and the counter wraps to 0 in that same shift update.

## Timing
- Raw input stable from edge 0: the conditioned level and edge pulse are visible after edge SYNC_STAGES+DEBOUNCE_CYCLES.
- Edge pulse to register update: 1 cycle. parallel_out is valid after the edge following the pulse.
- frame_done is asserted exactly one cycle, in the cycle after the register update of the WIDTH-th shift.
- Reset released mid-debounce: counting restarts from 0. No spurious edge pulse is generated at reset release, because the conditioned levels start at 0 and only a debounced change can produce a pulse.

## Configuration
- SHIFTREG_FRONTEND_FRAME_EN defined: bit counter and frame_done logic are present as described.
- Undefined: no counter flops are built and frame_done is tied to 0. All other behaviour is identical.

## Structure
- Shared package holds:
  - shift-direction constants: SHIFT_MSB_FIRST=0, SHIFT_LSB_FIRST=1;
  - the counter-width function, $clog2(WIDTH+1) wrapper;
  - default parameter values.
- One sub-module, input_conditioner: parametrised by SYNC_STAGES and DEBOUNCE_CYCLES; outputs conditioned, posedge, negedge. It is instantiated three times.

## Test plan
Parameters for all scenarios: WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
- Reset, then idle 20 cycles: parallel_out=0x00, serial_out=0, frame_done=0, no register change.
- switch1 pulsed high for 3 cycles: no shift, parallel_out unchanged. Held high for 10 cycles: exactly one shift, with the conditioned edge at edge 6 after the rise.
- button0 falls with parallel_in=0xA5, then 8 shifts with switch0=1 and lsb_first=0: parallel_out steps 0x4B, 0x97, … , 0xFF. frame_done pulses once, one cycle after the 8th shift.
- Load 0x81 with lsb_first=1, then one shift with switch0=0: parallel_out=0x40, serial_out=0.
- Conditioned button0 negedge and switch1 posedge in the same cycle with parallel_in=0x3C: parallel_out=0x3C, counter=0, and no frame_done after 7 further shifts.
- rst_n pulsed low after 5 shifts and mid-debounce of switch1: all outputs 0 immediately. A completed shift after release counts as 1, and frame_done follows only after 8 shifts.
